// File: rtl/lrf_axis_kernel_shell.sv
// lrf_axis_kernel_shell
// AXI-Stream shell around a fixed-latency, step-enabled pixel kernel.
// The kernel advances only on accepted input beats or during the end-of-frame
// drain; a tag pipe follows valid beats so each kernel result is pushed once.
// A credit counter bounds FIFO occupancy plus in-flight beats, so the output
// FIFO can never overflow. Output tlast is regenerated from a beat count.
// Optional build macro: LRF_FRAME_STATS_EN adds frame_cnt and bp_cycles ports.
module lrf_axis_kernel_shell #(
  parameter int DATA_W          = 128,
  parameter int LATENCY         = 10,
  parameter int BEATS_PER_FRAME = 16384,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              k_step,
  output logic [DATA_W-1:0] k_din,
  input  logic [DATA_W-1:0] k_dout,
  output logic              err_tlast
`ifdef LRF_FRAME_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [31:0]       bp_cycles
`endif
);

  localparam int IDX_W = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FL_W  = $clog2(LATENCY);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BEATS_PER_FRAME - 1);
  localparam logic [FL_W-1:0]  FL_LAST    = FL_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CRED_INIT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             state_r;
  logic               tready_r;
  logic [FL_W-1:0]    flush_cnt_r;
  logic [CNT_W-1:0]   credits_r;
  logic [CNT_W-1:0]   credits_nxt_s;
  logic [LATENCY-1:0] tag_r;
  logic               step_d1_r;
  logic [IDX_W-1:0]   in_idx_r;
  logic [IDX_W-1:0]   out_idx_r;
  logic [IDX_W-1:0]   out_idx_nxt_s;
  logic               err_r;
  logic [DATA_W-1:0]  mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_nxt_s;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_nxt_s;
  logic [DATA_W-1:0]  head_r;
  logic               valid_r;
  logic               tlast_r;
  logic               in_fire_s;
  logic               flush_step_s;
  logic               push_s;
  logic               pop_s;

  // Handshakes, kernel step and kernel input gating.
  always_comb begin
    in_fire_s    = s_axis_tvalid & tready_r;
    flush_step_s = (state_r == ST_FLUSH);
    pop_s        = valid_r & m_axis_tready;
    push_s       = step_d1_r & tag_r[LATENCY-1];
    k_step       = in_fire_s | flush_step_s;
    if (in_fire_s) begin
      k_din = s_axis_tdata;
    end else begin
      k_din = {DATA_W{1'b0}};
    end
  end

  // Next credit value: one credit per accepted beat, returned on output pop.
  always_comb begin
    credits_nxt_s = credits_r;
    case ({in_fire_s, pop_s})
      2'b10:   credits_nxt_s = credits_r - CNT_W'(1);
      2'b01:   credits_nxt_s = credits_r + CNT_W'(1);
      default: credits_nxt_s = credits_r;
    endcase
  end

  // Next FIFO occupancy, read pointer and head output index.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
      if (out_idx_r == LAST_IDX) begin
        out_idx_nxt_s = {IDX_W{1'b0}};
      end else begin
        out_idx_nxt_s = out_idx_r + IDX_W'(1);
      end
    end else begin
      rd_ptr_nxt_s  = rd_ptr_r;
      out_idx_nxt_s = out_idx_r;
    end
  end

  // Frame FSM: accept beats in RUN, drain the kernel for LATENCY steps at frame end.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_r     <= ST_IDLE;
      tready_r    <= 1'b0;
      flush_cnt_r <= {FL_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r  <= ST_RUN;
          tready_r <= (credits_nxt_s != {CNT_W{1'b0}});
        end
        ST_RUN: begin
          flush_cnt_r <= {FL_W{1'b0}};
          if (in_fire_s && (in_idx_r == LAST_IDX)) begin
            state_r  <= ST_FLUSH;
            tready_r <= 1'b0;
          end else begin
            tready_r <= (credits_nxt_s != {CNT_W{1'b0}});
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_r == FL_LAST) begin
            state_r  <= ST_RUN;
            tready_r <= (credits_nxt_s != {CNT_W{1'b0}});
          end else begin
            flush_cnt_r <= flush_cnt_r + FL_W'(1);
            tready_r    <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          tready_r <= 1'b0;
        end
      endcase
    end
  end

  // Credits, tag pipe, input beat index and sticky tlast error.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      credits_r <= CRED_INIT;
      tag_r     <= {LATENCY{1'b0}};
      step_d1_r <= 1'b0;
      in_idx_r  <= {IDX_W{1'b0}};
      err_r     <= 1'b0;
    end else begin
      credits_r <= credits_nxt_s;
      step_d1_r <= k_step;
      if (k_step) begin
        tag_r <= {tag_r[LATENCY-2:0], in_fire_s};
      end
      if (in_fire_s) begin
        if (s_axis_tlast != (in_idx_r == LAST_IDX)) begin
          err_r <= 1'b1;
        end
        if (in_idx_r == LAST_IDX) begin
          in_idx_r <= {IDX_W{1'b0}};
        end else begin
          in_idx_r <= in_idx_r + IDX_W'(1);
        end
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge s_axis_aclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= k_dout;
    end
  end

  // FIFO pointers plus registered head word, valid and regenerated tlast.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      out_idx_r <= {IDX_W{1'b0}};
      head_r    <= {DATA_W{1'b0}};
      valid_r   <= 1'b0;
      tlast_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r  <= rd_ptr_nxt_s;
      count_r   <= count_nxt_s;
      out_idx_r <= out_idx_nxt_s;
      // A word written into the slot the head is moving to bypasses the array.
      if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
        head_r <= k_dout;
      end else begin
        head_r <= mem_r[rd_ptr_nxt_s];
      end
      valid_r <= (count_nxt_s != {CNT_W{1'b0}});
      tlast_r <= (count_nxt_s != {CNT_W{1'b0}}) && (out_idx_nxt_s == LAST_IDX);
    end
  end

  assign s_axis_tready = tready_r;
  assign m_axis_tdata  = head_r;
  assign m_axis_tvalid = valid_r;
  assign m_axis_tlast  = tlast_r;
  assign err_tlast     = err_r;

`ifdef LRF_FRAME_STATS_EN
  logic [15:0] frame_cnt_r;
  logic [31:0] bp_cycles_r;

  // Completed output frames and saturating output backpressure cycles.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      frame_cnt_r <= 16'd0;
      bp_cycles_r <= 32'd0;
    end else begin
      if (pop_s && tlast_r) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      if (valid_r && !m_axis_tready && (bp_cycles_r != 32'hFFFF_FFFF)) begin
        bp_cycles_r <= bp_cycles_r + 32'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_r;
  assign bp_cycles = bp_cycles_r;
`endif

endmodule

// File: tb/tb_lrf_axis_kernel_shell.sv
// Bench for lrf_axis_kernel_shell with a 4-stage delay-line kernel model and
// a scoreboard of accepted beats compared against popped output beats.
module tb_lrf_axis_kernel_shell;

  localparam int DW  = 128;
  localparam int LAT = 4;
  localparam int BPF = 8;
  localparam int FD  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic          k_step;
  logic [DW-1:0] k_din;
  logic [DW-1:0] k_dout;
  logic          err_tlast;
`ifdef LRF_FRAME_STATS_EN
  logic [15:0]   frame_cnt;
  logic [31:0]   bp_cycles;
`endif

  lrf_axis_kernel_shell #(
    .DATA_W(DW), .LATENCY(LAT), .BEATS_PER_FRAME(BPF), .FIFO_DEPTH(FD)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .k_step        (k_step),
    .k_din         (k_din),
    .k_dout        (k_dout),
    .err_tlast     (err_tlast)
`ifdef LRF_FRAME_STATS_EN
    ,
    .frame_cnt     (frame_cnt),
    .bp_cycles     (bp_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Kernel model: delay line advancing only on k_step.
  logic [DW-1:0] kpipe [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) kpipe[i] <= '0;
    end else if (k_step) begin
      kpipe[0] <= k_din;
      for (int i = 1; i < LAT; i++) kpipe[i] <= kpipe[i-1];
    end
  end
  assign k_dout = kpipe[LAT-1];

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] sb [$];
  int exp_in_idx = 0;
  int exp_out_idx = 0;
  int flush_left = 0;
  int credits = FD;
  int cyc = 0;
  int outs_seen = 0;
  int lat_fire_cyc = -1;
  int lat_valid_cyc = -1;
  int exp_frames = 0;
  int exp_bp = 0;
  logic exp_err = 1'b0;

  typedef struct {
    int nin;
    int vpct;
    int rpct;
    int flip;
    int exp_outs;
  } vec_t;
  vec_t tbl [4];

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at the falling edge, check and update the model 1 time unit later.
  task automatic step_cycle(input logic v, input logic [DW-1:0] d, input logic l,
                            input logic mr, output logic fired);
    logic fire;
    logic pop;
    logic [DW-1:0] e;
    @(negedge clk);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    m_axis_tready = mr;
    #1;
    cyc++;
    fire = v & s_axis_tready;
    pop  = m_axis_tvalid & mr;
    check_bit("s_tready", s_axis_tready, (flush_left == 0) && (credits != 0));
    check_bit("err_tlast", err_tlast, exp_err);
    if (flush_left > 0) begin
      check_bit("flush_step", k_step, 1'b1);
      flush_left--;
    end else begin
      check_bit("k_step", k_step, fire);
    end
    if (fire) check_word("k_din", k_din, d);
    if (fire && lat_fire_cyc < 0) lat_fire_cyc = cyc;
    if (m_axis_tvalid && lat_valid_cyc < 0) lat_valid_cyc = cyc;
    if (m_axis_tvalid && !mr) exp_bp++;
    if (pop) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_extra: got beat %h expected none (cycle %0d)", m_axis_tdata, cyc);
      end else begin
        e = sb.pop_front();
        check_word("out_data", m_axis_tdata, e);
        check_bit("out_tlast", m_axis_tlast, exp_out_idx == BPF - 1);
      end
      if (exp_out_idx == BPF - 1) begin
        exp_out_idx = 0;
        exp_frames++;
      end else begin
        exp_out_idx++;
      end
      outs_seen++;
      credits++;
    end
    if (fire) begin
      sb.push_back(d);
      if (l != (exp_in_idx == BPF - 1)) exp_err = 1'b1;
      if (exp_in_idx == BPF - 1) begin
        exp_in_idx = 0;
        flush_left = LAT;
      end else begin
        exp_in_idx++;
      end
      credits--;
    end
    fired = fire;
  endtask

  // Offer nin beats with random valid/ready, then drain; flip marks a wrong-tlast index.
  task automatic run_traffic(input int nin, input int vpct, input int rpct,
                             input int flip, input int exp_outs);
    int fired_n;
    int start_outs;
    int c;
    logic hold;
    logic v;
    logic mr;
    logic l;
    logic f;
    logic [DW-1:0] d;
    fired_n = 0;
    start_outs = outs_seen;
    c = 0;
    hold = 1'b0;
    d = rnd();
    while (c < 3000 && !(fired_n >= nin && sb.size() == 0)) begin
      v  = (fired_n < nin) && (hold || ($urandom_range(0, 99) < vpct));
      mr = (fired_n >= nin) || ($urandom_range(0, 99) < rpct);
      l  = (exp_in_idx == BPF - 1) || (exp_in_idx == flip);
      step_cycle(v, d, l, mr, f);
      if (f) begin
        fired_n++;
        d = rnd();
        hold = 1'b0;
      end else begin
        hold = v;
      end
      c++;
    end
    if (c >= 3000) begin
      n_cmp++;
      n_err++;
      $display("FAIL traffic_timeout: got %0d beats in expected %0d", fired_n, nin);
    end
    check_int("beats_out", outs_seen - start_outs, exp_outs);
  endtask

  // Assert reset asynchronously mid-cycle, check outputs at once, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = rnd();
    m_axis_tready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("rst_s_tready", s_axis_tready, 1'b0);
    check_bit("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check_bit("rst_m_tlast", m_axis_tlast, 1'b0);
    check_word("rst_m_tdata", m_axis_tdata, '0);
    check_bit("rst_k_step", k_step, 1'b0);
    check_word("rst_k_din", k_din, '0);
    check_bit("rst_err_tlast", err_tlast, 1'b0);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    exp_in_idx = 0;
    exp_out_idx = 0;
    flush_left = 0;
    credits = FD;
    exp_err = 1'b0;
    exp_frames = 0;
    exp_bp = 0;
  endtask

  initial begin
    int acc;
    logic f;
    logic [DW-1:0] d;

    tbl[0] = '{nin: 32, vpct: 50,  rpct: 50,  flip: -1, exp_outs: 32};
    tbl[1] = '{nin: 16, vpct: 100, rpct: 30,  flip: -1, exp_outs: 16};
    tbl[2] = '{nin: 16, vpct: 30,  rpct: 100, flip: -1, exp_outs: 16};
    tbl[3] = '{nin: 24, vpct: 80,  rpct: 80,  flip: -1, exp_outs: 24};

    do_reset();

    // Streaming: one frame back to back, latency from accept to output valid.
    lat_fire_cyc = -1;
    lat_valid_cyc = -1;
    run_traffic(8, 100, 100, -1, 8);
    check_int("latency", lat_valid_cyc - lat_fire_cyc, LAT + 1);
    for (int i = 0; i < 5; i++) step_cycle(1'b0, '0, 1'b0, 1'b1, f);
    check_bit("tready_after_flush", s_axis_tready, 1'b1);

    // Backpressure: output held off, exactly FD beats accepted, then drained.
    acc = 0;
    d = rnd();
    for (int i = 0; i < 30; i++) begin
      step_cycle(1'b1, d, exp_in_idx == BPF - 1, 1'b0, f);
      if (f) begin
        acc++;
        d = rnd();
      end
    end
    check_int("bp_accepted", acc, FD);
    check_bit("bp_tready_low", s_axis_tready, 1'b0);
    run_traffic(0, 0, 100, -1, 8);

    // Random valid/ready phases from the table.
    for (int t = 0; t < 4; t++) begin
      run_traffic(tbl[t].nin, tbl[t].vpct, tbl[t].rpct, tbl[t].flip, tbl[t].exp_outs);
    end

    // Wrong tlast on beat 3: sticky error, framing still by count.
    run_traffic(8, 100, 100, 3, 8);
    check_bit("err_sticky", err_tlast, 1'b1);

    // Mid-frame async reset after 5 beats with output stalled.
    acc = 0;
    d = rnd();
    for (int i = 0; i < 50 && acc < 5; i++) begin
      step_cycle(1'b1, d, exp_in_idx == BPF - 1, 1'b0, f);
      if (f) begin
        acc++;
        d = rnd();
      end
    end
    check_int("pre_reset_beats", acc, 5);
    for (int i = 0; i < 3; i++) step_cycle(1'b0, '0, 1'b0, 1'b0, f);
    check_bit("pre_reset_valid", m_axis_tvalid, 1'b1);
    do_reset();
    run_traffic(8, 100, 100, -1, 8);

`ifdef LRF_FRAME_STATS_EN
    do_reset();
    run_traffic(24, 100, 60, -1, 24);
    step_cycle(1'b0, '0, 1'b0, 1'b1, f);
    check_int("frame_cnt", int'(frame_cnt), 3);
    check_int("frame_cnt_model", int'(frame_cnt), exp_frames);
    check_int("bp_cycles", int'(bp_cycles), exp_bp);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
